// File: rtl/dom_sbox_pkg.sv
// dom_sbox_pkg: shared randomness widths, pair indexing and GF(2^2) normal-basis multiply.
package dom_sbox_pkg;
  function automatic int mul_z_width(input int s);
    return s * (s - 1);
  endfunction
  function automatic int inv_z_width(input int s);
    return 2 * s * (s - 1);
  endfunction
  // Pairs i<j enumerated lexicographically; order of the arguments does not matter.
  function automatic int pair_idx(input int i, input int j, input int s);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * s - (lo * (lo + 1)) / 2 + hi - lo - 1;
  endfunction
  // Basis (W^2,W): bit1 is the W^2 coefficient, bit0 the W coefficient.
  function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction
endpackage

// File: rtl/dom_indep_mul_gf2.sv
// dom_indep_mul_gf2: DOM-indep shared GF(2^2) multiplier; cross terms always registered.
module dom_indep_mul_gf2
  import dom_sbox_pkg::*;
#(
  parameter int PIPELINED = 1,
  parameter int SHARES    = 2
) (
  input  logic                             ClkxCI,
  input  logic                             RstxBI,
  input  logic [2*SHARES-1:0]              AxDI,
  input  logic [2*SHARES-1:0]              BxDI,
  input  logic [mul_z_width(SHARES)-1:0]   ZxDI,
  output logic [2*SHARES-1:0]              QxDO
);
  logic [1:0] inner_d [SHARES];
  logic [1:0] inner_r [SHARES];
  logic [1:0] cross_d [SHARES][SHARES];
  logic [1:0] cross_q [SHARES][SHARES];

  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      inner_d[i] = gf2_mul(AxDI[2*i +: 2], BxDI[2*i +: 2]);
      for (int j = 0; j < SHARES; j++) begin
        int k;
        k = (i == j) ? 0 : pair_idx(i, j, SHARES);
        cross_d[i][j] = (i == j) ? 2'b00 : gf2_mul(AxDI[2*i +: 2], BxDI[2*j +: 2]) ^ ZxDI[2*k +: 2];
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      for (int i = 0; i < SHARES; i++)
        for (int j = 0; j < SHARES; j++)
          cross_q[i][j] <= 2'b00;
    end else begin
      cross_q <= cross_d;
    end
  end

  if (PIPELINED != 0) begin : g_pipe
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        for (int i = 0; i < SHARES; i++)
          inner_r[i] <= 2'b00;
      end else begin
        inner_r <= inner_d;
      end
    end
  end else begin : g_comb
    always_comb inner_r = inner_d;
  end

  // Each output share only ever mixes terms belonging to its own domain.
  always_comb begin
    QxDO = '0;
    for (int i = 0; i < SHARES; i++) begin
      QxDO[2*i +: 2] = inner_r[i];
      for (int j = 0; j < SHARES; j++)
        QxDO[2*i +: 2] = QxDO[2*i +: 2] ^ cross_q[i][j];
    end
  end
endmodule

// File: rtl/dom_shared_inv_out_mul_gf2.sv
// dom_shared_inv_out_mul_gf2: shared theta*X / theta*Y output stage of the masked GF(2^4) inverter.
// Define DOM_INV_OUT_REG_EN to add a glitch-free output register (latency 2 instead of 1).
module dom_shared_inv_out_mul_gf2
  import dom_sbox_pkg::*;
#(
  parameter int PIPELINED = 1,
  parameter int SHARES    = 2,
  parameter int XY_DELAY  = 1
) (
  input  logic                             ClkxCI,
  input  logic                             RstxBI,
  input  logic                             ValidxSI,
  input  logic [2*SHARES-1:0]              _ThetaxDI,
  input  logic [2*SHARES-1:0]              _XxDI,
  input  logic [2*SHARES-1:0]              _YxDI,
  input  logic [inv_z_width(SHARES)-1:0]   _ZxDI,
  output logic [2*SHARES-1:0]              _HxDO,
  output logic [2*SHARES-1:0]              _LxDO,
  output logic                             ValidxSO
);
  localparam int ZW = mul_z_width(SHARES);

  logic [4*SHARES-1:0] xy_al;
  logic [2*SHARES-1:0] h, l;
  logic                valid_d, valid_q;

  if (XY_DELAY == 0) begin : g_nodly
    assign xy_al = {_YxDI, _XxDI};
  end else begin : g_dly
    logic [4*SHARES-1:0] dly_d [XY_DELAY];
    logic [4*SHARES-1:0] dly_q [XY_DELAY];
    // Free-running alignment line: shifts every cycle, independent of valid.
    always_comb begin
      dly_d[0] = {_YxDI, _XxDI};
      for (int k = 1; k < XY_DELAY; k++)
        dly_d[k] = dly_q[k-1];
    end
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        for (int k = 0; k < XY_DELAY; k++)
          dly_q[k] <= '0;
      end else begin
        dly_q <= dly_d;
      end
    end
    assign xy_al = dly_q[XY_DELAY-1];
  end

  dom_indep_mul_gf2 #(.PIPELINED(PIPELINED), .SHARES(SHARES)) u_mul_h (
    .ClkxCI (ClkxCI),
    .RstxBI (RstxBI),
    .AxDI   (_ThetaxDI),
    .BxDI   (xy_al[2*SHARES-1:0]),
    .ZxDI   (_ZxDI[ZW-1:0]),
    .QxDO   (h)
  );

  dom_indep_mul_gf2 #(.PIPELINED(PIPELINED), .SHARES(SHARES)) u_mul_l (
    .ClkxCI (ClkxCI),
    .RstxBI (RstxBI),
    .AxDI   (_ThetaxDI),
    .BxDI   (xy_al[4*SHARES-1:2*SHARES]),
    .ZxDI   (_ZxDI[2*ZW-1:ZW]),
    .QxDO   (l)
  );

  always_comb valid_d = ValidxSI;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

`ifdef DOM_INV_OUT_REG_EN
  logic [2*SHARES-1:0] h_d, h_q, l_d, l_q;
  logic                vo_d, vo_q;
  always_comb begin
    h_d  = h;
    l_d  = l;
    vo_d = valid_q;
  end
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      h_q  <= '0;
      l_q  <= '0;
      vo_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      l_q  <= l_d;
      vo_q <= vo_d;
    end
  end
  assign _HxDO    = h_q;
  assign _LxDO    = l_q;
  assign ValidxSO = vo_q;
`else
  assign _HxDO    = h;
  assign _LxDO    = l;
  assign ValidxSO = valid_q;
`endif
endmodule

// File: tb/tb_dom_shared_inv_out_mul_gf2.sv
// tb_dom_shared_inv_out_mul_gf2: directed checks of the shared output multiplier (SHARES=2, XY_DELAY=1).
module tb_dom_shared_inv_out_mul_gf2;
`ifdef DOM_INV_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vin;
  logic [3:0] theta, x, y, z;
  logic [3:0] h, l;
  logic       vout;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  dom_shared_inv_out_mul_gf2 #(.PIPELINED(1), .SHARES(2), .XY_DELAY(1)) dut (
    .ClkxCI    (clk),
    .RstxBI    (rst_n),
    .ValidxSI  (vin),
    ._ThetaxDI (theta),
    ._XxDI     (x),
    ._YxDI     (y),
    ._ZxDI     (z),
    ._HxDO     (h),
    ._LxDO     (l),
    .ValidxSO  (vout)
  );

  // Reference via discrete log: 01=W, 10=W^2, 11=1 in the (W^2,W) basis.
  function automatic logic [1:0] gmul(input logic [1:0] a, input logic [1:0] b);
    int la, lb, e;
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    la = (a == 2'b11) ? 0 : (a == 2'b01) ? 1 : 2;
    lb = (b == 2'b11) ? 0 : (b == 2'b01) ? 1 : 2;
    e  = (la + lb) % 3;
    return (e == 0) ? 2'b11 : (e == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [3:0] msk(input logic [1:0] v);
    logic [1:0] r;
    r = 2'($urandom);
    return {v ^ r, r};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // X/Y one cycle ahead of theta; check unshared H/L and valid after LAT cycles.
  task automatic do_op(input logic [3:0] th, input logic [3:0] xs, input logic [3:0] ys, input string tag);
    logic [1:0] eh, el;
    eh = gmul(th[1:0] ^ th[3:2], xs[1:0] ^ xs[3:2]);
    el = gmul(th[1:0] ^ th[3:2], ys[1:0] ^ ys[3:2]);
    x = xs; y = ys; vin = 1'b0; theta = 4'($urandom); z = 4'($urandom);
    tick();
    theta = th; z = 4'($urandom); vin = 1'b1; x = 4'($urandom); y = 4'($urandom);
    tick();
    vin = 1'b0; theta = 4'($urandom);
    if (LAT == 2) tick();
    chk({tag, "_v"}, 8'(vout), 8'd1);
    chk({tag, "_h"}, 8'(h[1:0] ^ h[3:2]), 8'(eh));
    chk({tag, "_l"}, 8'(l[1:0] ^ l[3:2]), 8'(el));
  endtask

  initial begin
    logic       vpat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] h0_first;
    logic       varied;
    rst_n = 1'b0; vin = 1'b1;
    theta = 4'($urandom); x = 4'($urandom); y = 4'($urandom); z = 4'($urandom);
    repeat (3) begin
      @(posedge clk);
      theta = 4'($urandom); x = 4'($urandom); y = 4'($urandom); z = 4'($urandom);
    end
    #1;
    chk("rst_h", 8'(h), 8'h00);
    chk("rst_l", 8'(l), 8'h00);
    chk("rst_v", 8'(vout), 8'h00);
    vin = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    do_op(msk(2'b11), msk(2'b10), msk(2'b01), "ident");
    do_op(msk(2'b00), msk(2'b11), msk(2'b10), "zero_th");
    do_op(msk(2'b01), msk(2'b01), msk(2'b11), "w_times_w");

    varied = 1'b0;
    h0_first = 2'b00;
    for (int i = 0; i < 256; i++) begin
      do_op(msk(2'b01), msk(2'b10), msk(2'b11), "rnd");
      if (i == 0) h0_first = h[1:0];
      else if (h[1:0] != h0_first) varied = 1'b1;
    end
    chk("rnd_shares_vary", 8'(varied), 8'd1);

    tick();
    chk("bub_pre", 8'(vout), 8'd0);
    for (int n = 0; n < 6; n++) begin
      vin = vpat[n]; theta = 4'($urandom); z = 4'($urandom);
      tick();
      chk($sformatf("bub%0d", n), 8'(vout), (n - LAT + 1 >= 0) ? 8'(vpat[n - LAT + 1]) : 8'd0);
    end

    vin = 1'b1; theta = msk(2'b11); x = msk(2'b10); y = msk(2'b01);
    tick();
    vin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 8'(vout), 8'd0);
    chk("mid_rst_h", 8'(h), 8'h00);
    tick();
    rst_n = 1'b1;
    vin = 1'b1; theta = msk(2'b11); z = 4'($urandom); x = 4'($urandom); y = 4'($urandom);
    tick();
    vin = 1'b0;
    if (LAT == 2) tick();
    chk("post_rst_v", 8'(vout), 8'd1);
    chk("post_rst_h_dlyzero", 8'(h[1:0] ^ h[3:2]), 8'd0);
    chk("post_rst_l_dlyzero", 8'(l[1:0] ^ l[3:2]), 8'd0);
    repeat (LAT) tick();
    chk("post_rst_idle_v", 8'(vout), 8'd0);

    for (int t = 0; t < 16; t++)
      for (int s = 0; s < 16; s++)
        do_op(4'(t), 4'(s), 4'((s * 7 + t + 3) % 16), $sformatf("ex_t%0d_x%0d", t, s));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
